// File: rtl/rx_cmd_regfile.sv
// Serial command receiver with a small register file: deframes start/payload/parity/stop
// frames, one line bit per clk2 edge, and executes the opcode against the register file.
module rx_cmd_regfile #(
    parameter int DATA_W    = 4,
    parameter int ADDR_W    = 2,
    parameter int OP_W      = 4,
    parameter int PARITY_EN = 1
) (
    input  logic                            clk2,
    input  logic                            rst_n,
    input  logic                            transmission,
    output logic [DATA_W+ADDR_W+OP_W-1:0]   led_data,
    output logic [DATA_W-1:0]               display,
    output logic                            display_on,
    output logic                            frame_err,
    output logic                            cmd_err,
    output logic [7:0]                      err_count,
    output logic                            busy
);

    localparam int P     = DATA_W + ADDR_W + OP_W;
    localparam int NREGS = 1 << ADDR_W;
    localparam int IDX_W = (P > 1) ? $clog2(P) : 1;

    localparam logic [OP_W-1:0] OP_CLEAR      = OP_W'(1);
    localparam logic [OP_W-1:0] OP_STORE      = OP_W'(2);
    localparam logic [OP_W-1:0] OP_CLEAR_ALL  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SHOW       = OP_W'(4);
    localparam logic [OP_W-1:0] OP_STORE_SHOW = OP_W'(8);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        PARITY,
        STOP,
        WAIT_HIGH,
        EXEC
    } state_t;

    state_t                 state_reg, state_next;
    logic [IDX_W-1:0]       bit_idx_reg;
    logic [P-1:0]           payload_reg;
    logic                   mismatch_reg;
    logic [DATA_W-1:0]      regs_reg [NREGS];
    logic [DATA_W-1:0]      display_reg;
    logic                   display_on_reg;
    logic                   frame_err_reg, frame_err_next;
    logic                   cmd_err_reg, cmd_err_next;
    logic [7:0]             err_count_reg;
    logic                   exec_en;

    // Field views of the received payload (data in the low bits, opcode on top).
    logic [DATA_W-1:0]      fld_data;
    logic [ADDR_W-1:0]      fld_addr;
    logic [OP_W-1:0]        fld_op;
    logic                   op_known;
    logic                   op_writes;
    logic [NREGS-1:0]       wr_en;

    assign fld_data  = payload_reg[DATA_W-1:0];
    assign fld_addr  = payload_reg[DATA_W +: ADDR_W];
    assign fld_op    = payload_reg[P-1 -: OP_W];
    assign op_writes = (fld_op == OP_STORE) || (fld_op == OP_STORE_SHOW);
    assign op_known  = (fld_op == OP_CLEAR) || (fld_op == OP_CLEAR_ALL) ||
                       (fld_op == OP_SHOW)  || op_writes;

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_wr_en
            assign wr_en[gi] = exec_en && op_writes && (fld_addr == ADDR_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        frame_err_next = 1'b0;
        cmd_err_next   = 1'b0;
        exec_en        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!transmission) state_next = SHIFT;
            end
            SHIFT: begin
                if (bit_idx_reg == IDX_W'(P - 1))
                    state_next = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: begin
                state_next = STOP;
            end
            STOP: begin
                if (!transmission) begin
                    frame_err_next = 1'b1;
                    state_next     = WAIT_HIGH;
                end else if (mismatch_reg) begin
                    frame_err_next = 1'b1;
                    state_next     = IDLE;
                end else begin
                    state_next = EXEC;
                end
            end
            WAIT_HIGH: begin
                if (transmission) state_next = IDLE;
            end
            EXEC: begin
                exec_en      = 1'b1;
                cmd_err_next = !op_known;
                // A low line here is the start bit of a back-to-back frame.
                state_next   = transmission ? IDLE : SHIFT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            bit_idx_reg   <= '0;
            payload_reg   <= '0;
            mismatch_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            cmd_err_reg   <= 1'b0;
            err_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            frame_err_reg <= frame_err_next;
            cmd_err_reg   <= cmd_err_next;
            if (state_reg == SHIFT) begin
                bit_idx_reg              <= bit_idx_reg + 1'b1;
                payload_reg[bit_idx_reg] <= transmission;
                mismatch_reg             <= 1'b0;
            end else begin
                bit_idx_reg <= '0;
            end
            if (state_reg == PARITY)
                mismatch_reg <= (^payload_reg) ^ transmission;
            if ((frame_err_next || cmd_err_next) && (err_count_reg != 8'hFF))
                err_count_reg <= err_count_reg + 8'd1;
        end
    end

    // Flop array rather than RAM: CLEAR_ALL wipes every entry in one cycle.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (exec_en && (fld_op == OP_CLEAR_ALL))
                    regs_reg[i] <= '0;
                else if (wr_en[i])
                    regs_reg[i] <= fld_data;
            end
        end
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            display_reg    <= '0;
            display_on_reg <= 1'b0;
        end else if (exec_en) begin
            case (fld_op)
                OP_CLEAR: begin
                    display_on_reg <= 1'b0;
                end
                OP_CLEAR_ALL: begin
                    display_reg    <= '0;
                    display_on_reg <= 1'b0;
                end
                OP_SHOW: begin
                    display_reg    <= regs_reg[fld_addr];
                    display_on_reg <= 1'b1;
                end
                OP_STORE_SHOW: begin
                    // Show the incoming data, not the register's old contents.
                    display_reg    <= fld_data;
                    display_on_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign led_data   = payload_reg;
    assign display    = display_reg;
    assign display_on = display_on_reg;
    assign frame_err  = frame_err_reg;
    assign cmd_err    = cmd_err_reg;
    assign err_count  = err_count_reg;
    assign busy       = (state_reg != IDLE) && (state_reg != WAIT_HIGH);

endmodule

// File: tb/tb_rx_cmd_regfile.sv
// Scenario bench for rx_cmd_regfile: a behavioural model pushes expected results to a
// queue as each frame is sent; scenarios pop and compare at the EXEC / STOP edges.
module tb_rx_cmd_regfile;

    localparam int P = 10;

    logic           clk2 = 1'b0;
    logic           rst_n = 1'b0;
    logic           transmission = 1'b1;
    logic [P-1:0]   led_data;
    logic [3:0]     display;
    logic           display_on;
    logic           frame_err;
    logic           cmd_err;
    logic [7:0]     err_count;
    logic           busy;

    int checks = 0;
    int failures = 0;

    // Expected vector: {display, display_on, cmd_err, err_count}
    logic [13:0] sb_q[$];
    logic [13:0] exp_v;
    logic [13:0] obs_v;

    logic [3:0] m_regs [4];
    logic [3:0] m_display;
    logic       m_on;
    logic [7:0] m_cnt;

    rx_cmd_regfile #(.DATA_W(4), .ADDR_W(2), .OP_W(4), .PARITY_EN(1)) dut (
        .clk2        (clk2),
        .rst_n       (rst_n),
        .transmission(transmission),
        .led_data    (led_data),
        .display     (display),
        .display_on  (display_on),
        .frame_err   (frame_err),
        .cmd_err     (cmd_err),
        .err_count   (err_count),
        .busy        (busy)
    );

    always #5 clk2 = ~clk2;

    assign obs_v = {display, display_on, cmd_err, err_count};

    task automatic tick;
        @(posedge clk2);
        #1;
    endtask

    function automatic logic [P-1:0] mk(input logic [3:0] op, input logic [1:0] a,
                                        input logic [3:0] d);
        return {op, a, d};
    endfunction

    task automatic model_reset;
        for (int i = 0; i < 4; i++) m_regs[i] = 4'h0;
        m_display = 4'h0;
        m_on      = 1'b0;
        m_cnt     = 8'h00;
    endtask

    task automatic model_exec(input logic [P-1:0] pl);
        logic [3:0] op;
        logic [1:0] a;
        logic [3:0] d;
        logic       ce;
        op = pl[9:6];
        a  = pl[5:4];
        d  = pl[3:0];
        ce = 1'b0;
        case (op)
            4'd1: m_on = 1'b0;
            4'd2: m_regs[a] = d;
            4'd3: begin
                for (int i = 0; i < 4; i++) m_regs[i] = 4'h0;
                m_display = 4'h0;
                m_on = 1'b0;
            end
            4'd4: begin m_display = m_regs[a]; m_on = 1'b1; end
            4'd8: begin m_regs[a] = d; m_display = d; m_on = 1'b1; end
            default: ce = 1'b1;
        endcase
        if (ce && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        sb_q.push_back({m_display, m_on, ce, m_cnt});
    endtask

    task automatic model_frame_err;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        sb_q.push_back({m_display, m_on, 1'b0, m_cnt});
    endtask

    // Drives edges 0..12 of a frame (edge 0 skipped when the start bit was already
    // sampled in a preceding EXEC cycle); returns just after the stop-bit edge.
    task automatic send_frame(input logic [P-1:0] pl, input bit flip, input logic stop,
                              input bit with_start);
        if (with_start) begin transmission = 1'b0; tick(); end
        for (int k = 0; k < P; k++) begin transmission = pl[k]; tick(); end
        transmission = (^pl) ^ flip;
        tick();
        transmission = stop;
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        transmission = 1'b1;
        model_reset();
        tick();
        tick();
        checks++;
        if ({led_data, obs_v, frame_err, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0", {led_data, obs_v, frame_err, busy});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({led_data, obs_v, frame_err, busy} !== '0) begin
                failures++;
                $display("FAIL idle_outputs cycle=%0d got=%h required=0", i,
                         {led_data, obs_v, frame_err, busy});
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_store_show;
        logic [P-1:0] led_exp;
        send_frame(mk(4'd2, 2'd2, 4'hA), 1'b0, 1'b1, 1'b1);
        model_exec(mk(4'd2, 2'd2, 4'hA));
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL store_busy got=%b required=1", busy);
        end
        transmission = 1'b1;
        tick();
        exp_v = sb_q.pop_front();
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL store_exec got=%h required=%h", obs_v, exp_v);
        end
        send_frame(mk(4'd4, 2'd2, 4'hA), 1'b0, 1'b1, 1'b1);
        model_exec(mk(4'd4, 2'd2, 4'hA));
        checks++;
        if (display_on !== 1'b0) begin
            failures++;
            $display("FAIL show_early got=%b required=0", display_on);
        end
        tick();
        exp_v = sb_q.pop_front();
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL show_exec got=%h required=%h", obs_v, exp_v);
        end
        led_exp = 10'b0100_10_1010;
        checks++;
        if (led_data !== led_exp || busy !== 1'b0) begin
            failures++;
            $display("FAIL show_led got=%b busy=%b required=%b busy=0", led_data, busy, led_exp);
        end
        $display("test_store_show done display=%h", display);
    endtask

    task automatic test_back_to_back;
        send_frame(mk(4'd8, 2'd1, 4'h5), 1'b0, 1'b1, 1'b1);
        model_exec(mk(4'd8, 2'd1, 4'h5));
        transmission = 1'b0;
        tick();
        exp_v = sb_q.pop_front();
        checks++;
        if (obs_v !== exp_v || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first got=%h busy=%b required=%h busy=1", obs_v, busy, exp_v);
        end
        send_frame(mk(4'd4, 2'd2, 4'h0), 1'b0, 1'b1, 1'b0);
        model_exec(mk(4'd4, 2'd2, 4'h0));
        transmission = 1'b1;
        tick();
        exp_v = sb_q.pop_front();
        checks++;
        if (obs_v !== exp_v || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second got=%h ferr=%b required=%h ferr=0", obs_v, frame_err, exp_v);
        end
        send_frame(mk(4'd1, 2'd0, 4'h0), 1'b0, 1'b1, 1'b1);
        model_exec(mk(4'd1, 2'd0, 4'h0));
        tick();
        exp_v = sb_q.pop_front();
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL clear_exec got=%h required=%h", obs_v, exp_v);
        end
        $display("test_back_to_back done display=%h on=%b", display, display_on);
    endtask

    task automatic test_parity_err;
        send_frame(mk(4'd2, 2'd2, 4'h3), 1'b1, 1'b1, 1'b1);
        model_frame_err();
        exp_v = sb_q.pop_front();
        checks++;
        if (frame_err !== 1'b1 || obs_v !== exp_v || busy !== 1'b0) begin
            failures++;
            $display("FAIL parity_err got ferr=%b v=%h busy=%b required ferr=1 v=%h busy=0",
                     frame_err, obs_v, busy, exp_v);
        end
        transmission = 1'b1;
        tick();
        checks++;
        if (frame_err !== 1'b0 || err_count !== m_cnt) begin
            failures++;
            $display("FAIL parity_pulse got ferr=%b cnt=%0d required ferr=0 cnt=%0d",
                     frame_err, err_count, m_cnt);
        end
        send_frame(mk(4'd4, 2'd2, 4'h0), 1'b0, 1'b1, 1'b1);
        model_exec(mk(4'd4, 2'd2, 4'h0));
        tick();
        exp_v = sb_q.pop_front();
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL parity_reg_kept got=%h required=%h", obs_v, exp_v);
        end
        $display("test_parity_err done err_count=%0d", err_count);
    endtask

    task automatic test_stop_err;
        send_frame(mk(4'd2, 2'd1, 4'h9), 1'b0, 1'b0, 1'b1);
        model_frame_err();
        exp_v = sb_q.pop_front();
        checks++;
        if (frame_err !== 1'b1 || obs_v !== exp_v || led_data !== mk(4'd2, 2'd1, 4'h9)) begin
            failures++;
            $display("FAIL stop_err got ferr=%b v=%h led=%b required ferr=1 v=%h", frame_err,
                     obs_v, led_data, exp_v);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({busy, frame_err, cmd_err} !== 3'b000 || err_count !== m_cnt) begin
                failures++;
                $display("FAIL stop_hold cycle=%0d got busy/ferr/cerr=%b cnt=%0d required 000 cnt=%0d",
                         i, {busy, frame_err, cmd_err}, err_count, m_cnt);
            end
        end
        transmission = 1'b1;
        tick();
        send_frame(mk(4'd8, 2'd3, 4'h6), 1'b0, 1'b1, 1'b1);
        model_exec(mk(4'd8, 2'd3, 4'h6));
        tick();
        exp_v = sb_q.pop_front();
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL stop_recover got=%h required=%h", obs_v, exp_v);
        end
        send_frame(mk(4'd4, 2'd1, 4'h0), 1'b0, 1'b1, 1'b1);
        model_exec(mk(4'd4, 2'd1, 4'h0));
        tick();
        exp_v = sb_q.pop_front();
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL stop_reg_kept got=%h required=%h", obs_v, exp_v);
        end
        $display("test_stop_err done err_count=%0d", err_count);
    endtask

    task automatic test_cmd_err;
        send_frame(mk(4'd6, 2'd2, 4'hF), 1'b0, 1'b1, 1'b1);
        model_exec(mk(4'd6, 2'd2, 4'hF));
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL cmd_no_ferr got=%b required=0", frame_err);
        end
        tick();
        exp_v = sb_q.pop_front();
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL cmd_err got=%h required=%h", obs_v, exp_v);
        end
        tick();
        checks++;
        if (cmd_err !== 1'b0) begin
            failures++;
            $display("FAIL cmd_pulse got=%b required=0", cmd_err);
        end
        send_frame(mk(4'd3, 2'd0, 4'h0), 1'b0, 1'b1, 1'b1);
        model_exec(mk(4'd3, 2'd0, 4'h0));
        tick();
        exp_v = sb_q.pop_front();
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL clear_all got=%h required=%h", obs_v, exp_v);
        end
        send_frame(mk(4'd4, 2'd2, 4'h0), 1'b0, 1'b1, 1'b1);
        model_exec(mk(4'd4, 2'd2, 4'h0));
        tick();
        exp_v = sb_q.pop_front();
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL show_after_clear got=%h required=%h", obs_v, exp_v);
        end
        $display("test_cmd_err done display=%h on=%b", display, display_on);
    endtask

    task automatic test_reset_mid;
        send_frame(mk(4'd8, 2'd2, 4'h7), 1'b0, 1'b1, 1'b1);
        model_exec(mk(4'd8, 2'd2, 4'h7));
        tick();
        exp_v = sb_q.pop_front();
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL pre_reset got=%h required=%h", obs_v, exp_v);
        end
        transmission = 1'b0;
        tick();
        transmission = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy got=%b required=1", busy);
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({led_data, obs_v, frame_err, busy} !== '0) begin
            failures++;
            $display("FAIL mid_reset got=%h required=0", {led_data, obs_v, frame_err, busy});
        end
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(mk(4'd4, 2'd2, 4'h0), 1'b0, 1'b1, 1'b1);
        model_exec(mk(4'd4, 2'd2, 4'h0));
        tick();
        exp_v = sb_q.pop_front();
        checks++;
        if (obs_v !== exp_v || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got=%h ferr=%b required=%h ferr=0", obs_v, frame_err, exp_v);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 260; i++) begin
            send_frame(mk(4'd0, 2'd0, 4'h0), 1'b0, 1'b1, i == 0);
            model_exec(mk(4'd0, 2'd0, 4'h0));
            transmission = (i == 259) ? 1'b1 : 1'b0;
            tick();
            exp_v = sb_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL saturate frame=%0d got=%h required=%h", i, obs_v, exp_v);
            end
        end
        $display("test_saturation done err_count=%0d", err_count);
    endtask

    initial begin
        test_reset();
        test_store_show();
        test_back_to_back();
        test_parity_err();
        test_stop_err();
        test_cmd_err();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
